edge_detect_multi: RTL

- Parametrised multi-channel successor to the single-bit edge detector.
- Each of WIDTH asynchronous inputs passes through a synchroniser and, optionally, a debounce filter. The block then reports one-cycle edge pulses, with a mode selected per channel.
- Per-channel sticky flags and saturating edge counters are provided for software-style polling.
- Sits between raw external inputs (buttons, async strobes) and the control FSMs.

---
 rtl/edge_detect_multi.sv | 124 ++++++++++++
 1 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised edge detector with per-channel mode, sticky flag and saturating counter.
// Optional debounce filter enabled by defining EDGE_DEBOUNCE_EN.
module edge_detect_multi #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int CNT_W           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         x,
   input  logic [2*WIDTH-1:0]       mode,
   input  logic [WIDTH-1:0]         clr,
   output logic [WIDTH-1:0]         y,
   output logic [WIDTH-1:0]         flag,
   output logic [WIDTH*CNT_W-1:0]   cnt
);

   // Edges stay masked until s and s_d both hold samples taken after reset.
`ifdef EDGE_DEBOUNCE_EN
   localparam int PRIME = SYNC_STAGES + DEBOUNCE_CYCLES + 2;
`else
   localparam int PRIME = SYNC_STAGES + 2 + 0 * DEBOUNCE_CYCLES;
`endif
   localparam int PW = $clog2(PRIME + 1);

   logic [SYNC_STAGES-1:0] sh [WIDTH];
   logic [WIDTH-1:0]       sync;
   logic [WIDTH-1:0]       filt;
   logic [WIDTH-1:0]       s;
   logic [WIDTH-1:0]       s_d;
   logic [WIDTH-1:0]       rise;
   logic [WIDTH-1:0]       fall;
   logic [WIDTH-1:0]       hit;
   logic [WIDTH-1:0]       acc;
   logic [CNT_W-1:0]       cntr [WIDTH];
   logic [PW-1:0]          pcnt;
   logic                   primed;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      assign sync[g]                 = sh[g][SYNC_STAGES-1];
      assign cnt[CNT_W*g +: CNT_W]   = cntr[g];
   end

`ifdef EDGE_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DW-1:0] dcnt [WIDTH];

   // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            dcnt[i] <= '0;
            filt[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] != filt[i]) begin
               if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                  filt[i] <= sync[i];
                  dcnt[i] <= '0;
               end else begin
                  dcnt[i] <= dcnt[i] + 1'b1;
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end
`else
   assign filt = sync;
`endif

   always_comb begin
      hit    = '0;
      primed = (pcnt == '0);
      rise   = s & ~s_d;
      fall   = ~s & s_d;
      for (int i = 0; i < WIDTH; i++) begin
         hit[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
      end
      acc = hit & {WIDTH{primed}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            sh[i]   <= '0;
            cntr[i] <= '0;
         end
         s    <= '0;
         s_d  <= '0;
         y    <= '0;
         flag <= '0;
         pcnt <= PW'(PRIME);
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            sh[i] <= {sh[i][SYNC_STAGES-2:0], x[i]};
         end
         s   <= filt;
         s_d <= s;
         y   <= acc;
         if (!primed) begin
            pcnt <= pcnt - 1'b1;
         end
         // A new edge beats a simultaneous clear: flag stays set and the counter restarts at 1.
         for (int i = 0; i < WIDTH; i++) begin
            if (acc[i]) begin
               flag[i] <= 1'b1;
            end else if (clr[i]) begin
               flag[i] <= 1'b0;
            end
            if (clr[i]) begin
               cntr[i] <= acc[i] ? CNT_W'(1) : '0;
            end else if (acc[i] && (cntr[i] != '1)) begin
               cntr[i] <= cntr[i] + 1'b1;
            end
         end
      end
   end

endmodule
